// File: rtl/mul_div.sv
// mul_div : iterative multiply / divide unit for the S1C88 core.
//
// Purpose:
//   MLT : R = A[7:0] * B (shift-add, one multiplier bit per cycle, 8 cycles)
//   DIV : A / B restoring division, one quotient bit per cycle, 16 cycles.
//         R = {remainder, quotient} when the quotient fits in 8 bits,
//         otherwise R keeps the dividend and V is raised.
//         A zero divisor finishes after a single cycle with div_zero set.
//   Results and flags feed the ALU writeback path, so flags use the ALU
//   ordering {S,V,C,Z}.
//
// Ports:
//   clk      in   core clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   request, sampled only when not busy (IDLE or done cycle)
//   op       in   0 = MLT, 1 = DIV, latched with start
//   A        in   16-bit dividend / multiplicand in A[7:0]
//   B        in   8-bit multiplier / divisor
//   flush    in   synchronous abort, highest priority, no done follows
//   busy     out  operation in progress
//   done     out  one-cycle completion pulse
//   R        out  16-bit result, held until the next completion
//   flags    out  {S,V,C,Z}
//   div_zero out  qualifies done: divisor was zero
module mul_div (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [15:0] R,
  output logic [3:0]  flags,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] work_q, work_d;
  logic [15:0] opnd_q, opnd_d;
  logic [7:0]  mplr_q, mplr_d;
  logic [8:0]  rem_q, rem_d;
  logic [15:0] dvd_q, dvd_d;
  logic [15:0] res_q, res_d;
  logic [3:0]  flags_q, flags_d;
  logic        divZero_q, divZero_d;

  logic        launch;
  logic        mulLast;
  logic        divZeroHit;
  logic        divLast;
  logic [15:0] mulSum;
  logic [9:0]  remShift;
  logic        qBit;
  logic [8:0]  remNext;
  logic [15:0] quoNext;

  // The done cycle (FIN) accepts a new start exactly like IDLE, which is
  // what gives back-to-back throughput of N+1 cycles.
  assign launch = start && !flush && ((state_q == IDLE) || (state_q == FIN));

  assign mulLast    = (state_q == MUL) && (cnt_q == 4'd7);
  assign divZeroHit = (state_q == DIV) && (mplr_q == 8'h00);
  assign divLast    = (state_q == DIV) && (cnt_q == 4'd15);

  // One shift-add step: work_q is the accumulator, opnd_q the multiplicand
  // already shifted to the weight of the multiplier bit in mplr_q[0].
  assign mulSum = work_q + (mplr_q[0] ? opnd_q : 16'h0000);

  // One restoring-division step. work_q starts as the dividend and turns into
  // the quotient as dividend bits shift out of the top and quotient bits shift
  // in at the bottom. The remainder is always below the divisor, so the
  // shifted value needs the ninth bit to compare without overflow.
  assign remShift = {rem_q, work_q[15]};
  assign qBit     = (remShift >= {2'b00, mplr_q});
  assign remNext  = qBit ? 9'(remShift - {2'b00, mplr_q}) : remShift[8:0];
  assign quoNext  = {work_q[14:0], qBit};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A zero divisor spends a single DIV cycle, in which the
  // latched divisor is seen to be zero, and then goes straight to FIN without
  // iterating. Flush overrides everything, including completion and start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, FIN: state_d = start ? (op ? DIV : MUL) : IDLE;
      MUL:       if (cnt_q == 4'd7) state_d = FIN;
      DIV:       if ((mplr_q == 8'h00) || (cnt_q == 4'd15)) state_d = FIN;
      default:   state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // Outputs decoded from the state alone.
  always_comb begin
    busy = (state_q == MUL) || (state_q == DIV);
    done = (state_q == FIN);
  end

  // Datapath next values. Result registers only change on the completing
  // edge, so R and flags never expose intermediate values; a flush on that
  // same edge suppresses the write.
  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    opnd_d    = opnd_q;
    mplr_d    = mplr_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    res_d     = res_q;
    flags_d   = flags_q;
    divZero_d = divZero_q;

    if (launch) begin
      work_d = op ? A : 16'h0000;
      opnd_d = {8'h00, A[7:0]};
      mplr_d = B;
      rem_d  = 9'h000;
      dvd_d  = A;
      cnt_d  = 4'd0;
    end else if (state_q == MUL) begin
      work_d = mulSum;
      opnd_d = opnd_q << 1;
      mplr_d = mplr_q >> 1;
      cnt_d  = cnt_q + 4'd1;
    end else if (state_q == DIV) begin
      work_d = quoNext;
      rem_d  = remNext;
      cnt_d  = cnt_q + 4'd1;
    end

    if (!flush) begin
      if (mulLast) begin
        res_d     = mulSum;
        flags_d   = {mulSum[15], 2'b00, (mulSum == 16'h0000)};
        divZero_d = 1'b0;
      end else if (divZeroHit) begin
        res_d     = dvd_q;
        flags_d   = 4'b0000;
        divZero_d = 1'b1;
      end else if (divLast) begin
        divZero_d = 1'b0;
        if (quoNext[15:8] != 8'h00) begin
          res_d   = dvd_q;
          flags_d = 4'b0100;
        end else begin
          res_d   = {remNext[7:0], quoNext[7:0]};
          flags_d = {quoNext[7], 2'b00, (quoNext[7:0] == 8'h00)};
        end
      end
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= 4'd0;
      work_q    <= 16'h0000;
      opnd_q    <= 16'h0000;
      mplr_q    <= 8'h00;
      rem_q     <= 9'h000;
      dvd_q     <= 16'h0000;
      res_q     <= 16'h0000;
      flags_q   <= 4'b0000;
      divZero_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      mplr_q    <= mplr_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      divZero_q <= divZero_d;
    end
  end

  assign R        = res_q;
  assign flags    = flags_q;
  assign div_zero = divZero_q;

endmodule
